// File: rtl/eth_rx_stream_checker.sv
// AXI4-Stream receive checker: verifies lane pattern, tkeep and frame length, and keeps saturating stats.
// Optional build macro ETH_RX_STREAM_CHECKER_BACKPRESSURE_EN drives s_tready from a 16-bit LFSR.
module eth_rx_stream_checker #(
  parameter int C_S_TDATA_WIDTH = 512
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic [C_S_TDATA_WIDTH-1:0]   s_tdata,
  input  logic [C_S_TDATA_WIDTH/8-1:0] s_tkeep,
  input  logic                         s_tlast,
  input  logic [31:0]                  ctrl_xfer_size_in_bytes,
  input  logic [31:0]                  ctrl_constant,
  input  logic                         ctrl_clear,
  output logic [31:0]                  stat_frames_ok,
  output logic [31:0]                  stat_frames_err,
  output logic [47:0]                  stat_bytes,
  output logic                         err_pulse,
  output logic                         busy
);

  localparam int KW = C_S_TDATA_WIDTH / 8;
  localparam int NL = C_S_TDATA_WIDTH / 32;
  localparam int CW = $clog2(KW + 1);

  typedef enum logic [1:0] {IDLE, RECV, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] beat_q, beat_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] const_q, const_d;
  logic        err_q, err_d;
  logic        ready_en_q;

  logic          accept, final_beat, data_bad, keep_bad, beat_err, frame_done, frame_bad;
  logic [31:0]   cur_rem, cur_const, cur_beat, base, exp_lane;
  logic [KW-1:0] exp_keep;
  logic [CW-1:0] byte_cnt;
  logic [48:0]   bytes_sum;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    accept     = s_tvalid & s_tready;
    cur_rem    = rem_q;
    cur_const  = const_q;
    cur_beat   = beat_q;
    if (state_q == IDLE) begin
      // Beat 0 takes length and seed straight from the control inputs.
      cur_rem   = (ctrl_xfer_size_in_bytes == 32'd0) ? 32'(KW) : ctrl_xfer_size_in_bytes;
      cur_const = ctrl_constant;
      cur_beat  = 32'd0;
    end
    base       = cur_const + cur_beat * 32'(NL);
    final_beat = (cur_rem <= 32'(KW));

    exp_keep = '0;
    for (int j = 0; j < KW; j++) exp_keep[j] = (32'(j) < cur_rem);
    keep_bad = (s_tkeep != exp_keep);

    data_bad = 1'b0;
    exp_lane = '0;
    for (int i = 0; i < NL; i++) begin
      exp_lane = base + 32'(i);
      for (int k = 0; k < 4; k++)
        if (s_tkeep[4*i+k] && (s_tdata[32*i+8*k +: 8] != exp_lane[8*k +: 8])) data_bad = 1'b1;
    end

    // Early tlast and missing tlast at the length boundary are both length errors.
    beat_err   = (state_q != DRAIN) &&
                 (data_bad || keep_bad || (s_tlast && !final_beat) || (!s_tlast && final_beat));
    frame_done = accept & s_tlast;
    frame_bad  = err_q | beat_err;

    byte_cnt = '0;
    for (int j = 0; j < KW; j++) byte_cnt = byte_cnt + {{(CW-1){1'b0}}, s_tkeep[j]};
    bytes_sum = {1'b0, stat_bytes} + 49'(byte_cnt);

    state_d = state_q;
    beat_d  = beat_q;
    rem_d   = rem_q;
    const_d = const_q;
    err_d   = err_q;
    if (accept) begin
      const_d = cur_const;
      rem_d   = final_beat ? 32'd0 : cur_rem - 32'(KW);
      if (s_tlast) begin
        state_d = IDLE;
        beat_d  = 32'd0;
        err_d   = 1'b0;
      end else begin
        beat_d  = cur_beat + 32'd1;
        err_d   = frame_bad;
        state_d = frame_bad ? DRAIN : RECV;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q         <= IDLE;
      beat_q          <= '0;
      rem_q           <= '0;
      const_q         <= '0;
      err_q           <= 1'b0;
      ready_en_q      <= 1'b0;
      err_pulse       <= 1'b0;
      stat_frames_ok  <= '0;
      stat_frames_err <= '0;
      stat_bytes      <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      rem_q      <= rem_d;
      const_q    <= const_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
      err_pulse  <= frame_done & frame_bad;
      // Clear wins over any increment landing on the same edge.
      if (ctrl_clear) begin
        stat_frames_ok  <= '0;
        stat_frames_err <= '0;
        stat_bytes      <= '0;
      end else begin
        if (accept) stat_bytes <= bytes_sum[48] ? '1 : bytes_sum[47:0];
        if (frame_done && !frame_bad && (stat_frames_ok != '1))
          stat_frames_ok <= stat_frames_ok + 32'd1;
        if (frame_done && frame_bad && (stat_frames_err != '1))
          stat_frames_err <= stat_frames_err + 32'd1;
      end
    end
  end

`ifdef ETH_RX_STREAM_CHECKER_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) lfsr_q <= 16'hACE1;
    else           lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign s_tready = ready_en_q & lfsr_q[0];
`else
  assign s_tready = ready_en_q;
`endif

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_eth_rx_stream_checker.sv
// Scoreboard bench for eth_rx_stream_checker: frame verdicts are queued at stimulus time and
// popped when the DUT reports a frame; byte count is compared after every accepted beat.
module tb_eth_rx_stream_checker;

  localparam int W  = 512;
  localparam int KW = W / 8;
  localparam int NL = W / 32;

  logic          ap_clk, ap_rst_n;
  logic          s_tvalid, s_tready, s_tlast;
  logic [W-1:0]  s_tdata;
  logic [KW-1:0] s_tkeep;
  logic [31:0]   ctrl_xfer_size_in_bytes, ctrl_constant;
  logic          ctrl_clear;
  logic [31:0]   stat_frames_ok, stat_frames_err;
  logic [47:0]   stat_bytes;
  logic          err_pulse, busy;

  int     tests_run    = 0;
  int     tests_failed = 0;
  int     pulse_cnt    = 0;
  longint exp_bytes    = 0;
  bit     abort        = 0;
  bit     sb[$];

  eth_rx_stream_checker #(.C_S_TDATA_WIDTH(W)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .ctrl_xfer_size_in_bytes(ctrl_xfer_size_in_bytes), .ctrl_constant(ctrl_constant),
    .ctrl_clear(ctrl_clear),
    .stat_frames_ok(stat_frames_ok), .stat_frames_err(stat_frames_err),
    .stat_bytes(stat_bytes), .err_pulse(err_pulse), .busy(busy)
  );

  initial begin
    ap_clk = 1'b0;
    forever #5 ap_clk = ~ap_clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Frame monitor: any counter step or error pulse consumes one queued verdict.
  initial begin
    logic [31:0] prev_ok, prev_err;
    bit ok_inc, err_inc, pulse, bad;
    prev_ok  = '0;
    prev_err = '0;
    forever begin
      @(negedge ap_clk);
      ok_inc  = (stat_frames_ok == prev_ok + 32'd1);
      err_inc = (stat_frames_err == prev_err + 32'd1);
      pulse   = err_pulse;
      if (pulse) pulse_cnt++;
      if (ok_inc || err_inc || pulse) begin
        tests_run++;
        if (sb.size() == 0) begin
          tests_failed++;
          $display("FAIL sb_unexpected_frame: ok_inc=%0b err_inc=%0b pulse=%0b, required no frame",
                   ok_inc, err_inc, pulse);
        end else begin
          bad = sb.pop_front();
          if ({ok_inc, err_inc, pulse} !== {!bad, bad, bad}) begin
            tests_failed++;
            $display("FAIL sb_frame_verdict: {ok_inc,err_inc,pulse}=%3b, required %3b",
                     {ok_inc, err_inc, pulse}, {!bad, bad, bad});
          end
        end
      end
      prev_ok  = stat_frames_ok;
      prev_err = stat_frames_err;
    end
  end

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic send_beat();
    int waited = 0;
    bit rdy;
    bit acc = 0;
    while (!acc) begin
      rdy = s_tready;
      @(negedge ap_clk);
      if (rdy) acc = 1;
      else begin
        waited++;
        if (waited > 500) begin
          tests_run++;
          tests_failed++;
          $display("FAIL beat_accept_timeout: s_tready low for %0d cycles, required acceptance", waited);
          abort = 1;
          return;
        end
      end
    end
    exp_bytes = ctrl_clear ? 0 : exp_bytes + $countones(s_tkeep);
    tests_run++;
    if (stat_bytes !== 48'(exp_bytes)) begin
      tests_failed++;
      $display("FAIL beat_stat_bytes: got %0d, required %0d", stat_bytes, exp_bytes);
    end
  endtask

  // last_beat<0: tlast on the natural final beat; stop_at>=0: leave that beat driven and return.
  task automatic send_frame(input int len, input logic [31:0] c, input int last_beat,
                            input int bad_beat, input int bad_lane, input bit bad_keep,
                            input bit clear_last, input int stop_at);
    int n, eff, lb, rem;
    logic [W-1:0]  d;
    logic [KW-1:0] k, one;
    bit bad;
    one = 1;
    n   = (len == 0) ? 1 : (len + KW - 1) / KW;
    eff = (len == 0) ? KW : len;
    lb  = (last_beat < 0) ? n - 1 : last_beat;
    bad = (lb != n - 1) || (bad_beat >= 0 && bad_beat <= lb) || bad_keep;
    ctrl_xfer_size_in_bytes = 32'(len);
    ctrl_constant           = c;
    for (int b = 0; b <= lb; b++) begin
      if (abort) return;
      rem = eff - b * KW;
      if (rem >= KW || rem <= 0) k = '1;
      else k = (one << rem) - one;
      for (int i = 0; i < NL; i++) d[32*i +: 32] = c + 32'(b * NL + i);
      if (b == bad_beat) d[32*bad_lane +: 32] = d[32*bad_lane +: 32] ^ 32'h0000_0100;
      if (b == lb && bad_keep) k[KW-1] = ~k[KW-1];
      s_tdata  = d;
      s_tkeep  = k;
      s_tlast  = (b == lb);
      s_tvalid = 1'b1;
      if (b == stop_at) return;
      if (b == lb) begin
        if (clear_last) ctrl_clear = 1'b1;
        else sb.push_back(bad);
      end
      send_beat();
      ctrl_clear = 1'b0;
      if (b == 0) begin
        ctrl_xfer_size_in_bytes = 32'hDEAD;
        ctrl_constant           = $urandom;
      end
    end
  endtask

  task automatic wait_sb();
    int w = 0;
    while (sb.size() != 0 && w < 10) begin
      @(negedge ap_clk);
      w++;
    end
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL sb_drain: %0d frames never reported, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    ap_rst_n = 1'b0;
    repeat (3) @(negedge ap_clk);
    tests_run++;
    if ({s_tready, busy, err_pulse} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_ctrl: {tready,busy,err_pulse}=%3b, required 000", {s_tready, busy, err_pulse});
    end
    tests_run++;
    if (stat_frames_ok !== 32'd0 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd0) begin
      tests_failed++;
      $display("FAIL reset_stats: ok=%0d err=%0d bytes=%0d, required 0 0 0",
               stat_frames_ok, stat_frames_err, stat_bytes);
    end
    ap_rst_n = 1'b1;
    tests_run++;
    if (s_tready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_release_ready: tready=%b before first edge out of reset, required 0", s_tready);
    end
    @(negedge ap_clk);
`ifndef ETH_RX_STREAM_CHECKER_BACKPRESSURE_EN
    tests_run++;
    if (s_tready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_ready_up: tready=%b, required 1", s_tready);
    end
`endif
    exp_bytes = 0;
  endtask

  task automatic test_long_frame();
    int p0 = pulse_cnt;
    send_frame(16384, 32'd1, -1, -1, 0, 0, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok !== 32'd1 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd16384) begin
      tests_failed++;
      $display("FAIL long_frame_stats: ok=%0d err=%0d bytes=%0d, required 1 0 16384",
               stat_frames_ok, stat_frames_err, stat_bytes);
    end
    tests_run++;
    if (pulse_cnt !== p0) begin
      tests_failed++;
      $display("FAIL long_frame_pulse: %0d pulses, required 0", pulse_cnt - p0);
    end
  endtask

  task automatic test_wrap();
    send_frame(100, 32'hFFFF_FFF0, -1, -1, 0, 0, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok !== 32'd2 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd16484) begin
      tests_failed++;
      $display("FAIL wrap_stats: ok=%0d err=%0d bytes=%0d, required 2 0 16484",
               stat_frames_ok, stat_frames_err, stat_bytes);
    end
  endtask

  task automatic test_single_beat();
    logic [31:0] ok0 = stat_frames_ok, er0 = stat_frames_err;
    send_frame(0, 32'd5, -1, -1, 0, 0, 0, -1);
    send_frame(10, 32'd7, -1, -1, 0, 0, 0, -1);
    send_frame(10, 32'd9, -1, -1, 0, 1, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok - ok0 !== 32'd2 || stat_frames_err - er0 !== 32'd1) begin
      tests_failed++;
      $display("FAIL single_beat_counts: ok+%0d err+%0d, required ok+2 err+1",
               stat_frames_ok - ok0, stat_frames_err - er0);
    end
  endtask

  task automatic test_corrupt();
    logic [31:0] ok0 = stat_frames_ok, er0 = stat_frames_err;
    int p0 = pulse_cnt;
    send_frame(256, 32'h1234_0000, -1, 1, 3, 0, 0, -1);
    idle(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL corrupt_idle: busy=%b after drained tlast, required 0", busy);
    end
    send_frame(256, 32'h0000_0055, -1, -1, 0, 0, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok - ok0 !== 32'd1 || stat_frames_err - er0 !== 32'd1 || pulse_cnt - p0 != 1) begin
      tests_failed++;
      $display("FAIL corrupt_counts: ok+%0d err+%0d pulses %0d, required ok+1 err+1 pulses 1",
               stat_frames_ok - ok0, stat_frames_err - er0, pulse_cnt - p0);
    end
  endtask

  task automatic test_length();
    logic [31:0] ok0 = stat_frames_ok, er0 = stat_frames_err;
    send_frame(256, 32'hA000_0000, 1, -1, 0, 0, 0, -1);
    idle(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_idle: busy=%b, required 0", busy);
    end
    send_frame(256, 32'hB000_0000, 5, -1, 0, 0, 0, -1);
    idle(1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL late_idle: busy=%b, required 0", busy);
    end
    wait_sb();
    tests_run++;
    if (stat_frames_err - er0 !== 32'd2 || stat_frames_ok - ok0 !== 32'd0) begin
      tests_failed++;
      $display("FAIL length_counts: ok+%0d err+%0d, required ok+0 err+2",
               stat_frames_ok - ok0, stat_frames_err - er0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ok0 = stat_frames_ok, er0 = stat_frames_err;
    send_frame(200, 32'h0000_1000, -1, -1, 0, 0, 0, -1);
    send_frame(128, 32'h0000_2000, -1, 0, 0, 0, 0, -1);
    send_frame(64, 32'h0000_3000, -1, -1, 0, 0, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok - ok0 !== 32'd2 || stat_frames_err - er0 !== 32'd1) begin
      tests_failed++;
      $display("FAIL b2b_counts: ok+%0d err+%0d, required ok+2 err+1",
               stat_frames_ok - ok0, stat_frames_err - er0);
    end
  endtask

  task automatic test_clear();
    send_frame(128, 32'h0000_0009, -1, -1, 0, 0, 1, -1);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    tests_run++;
    if (stat_frames_ok !== 32'd0 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd0) begin
      tests_failed++;
      $display("FAIL clear_stats: ok=%0d err=%0d bytes=%0d, required 0 0 0",
               stat_frames_ok, stat_frames_err, stat_bytes);
    end
    idle(2);
    tests_run++;
    if (stat_frames_ok !== 32'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL clear_hold: ok=%0d busy=%b, required 0 0", stat_frames_ok, busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(16384, 32'd1, -1, -1, 0, 0, 0, 100);
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    ap_rst_n  = 1'b1;
    exp_bytes = 0;
    @(negedge ap_clk);
    tests_run++;
    if (stat_frames_ok !== 32'd0 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midreset_state: ok=%0d err=%0d bytes=%0d busy=%b, required 0 0 0 0",
               stat_frames_ok, stat_frames_err, stat_bytes, busy);
    end
    send_frame(16384, 32'd1, -1, -1, 0, 0, 0, -1);
    idle(2);
    wait_sb();
    tests_run++;
    if (stat_frames_ok !== 32'd1 || stat_frames_err !== 32'd0 || stat_bytes !== 48'd16384) begin
      tests_failed++;
      $display("FAIL midreset_stats: ok=%0d err=%0d bytes=%0d, required 1 0 16384",
               stat_frames_ok, stat_frames_err, stat_bytes);
    end
  endtask

  initial begin
    ap_rst_n                = 1'b0;
    s_tvalid                = 1'b0;
    s_tlast                 = 1'b0;
    s_tdata                 = '0;
    s_tkeep                 = '0;
    ctrl_xfer_size_in_bytes = '0;
    ctrl_constant           = '0;
    ctrl_clear              = 1'b0;
    test_reset();
    test_long_frame();
    test_wrap();
    test_single_beat();
    test_corrupt();
    test_length();
    test_back_to_back();
    test_clear();
    test_reset_mid_frame();
    idle(2);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
